// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and default timing constants.
package rst_sequencer_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } seq_state_e;

  localparam int unsigned DefaultStretch = 32'h0000_FFFF;
  localparam int unsigned DefaultStagger = 32'd16;

endpackage

// File: rtl/rst_sequencer_sync.sv
// Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES rising edges of clk.
module rst_sequencer_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: stretches the synchronised board reset, then releases N_OUT domains in order.
// Optional watchdog that restarts the sequence is enabled by defining RST_SEQ_WDOG_EN.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STRETCH     = DefaultStretch,
  parameter int unsigned STAGGER     = DefaultStagger,
  parameter int unsigned SYNC_STAGES = 2
`ifdef RST_SEQ_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 32'd1 << 20
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst_req,
`ifdef RST_SEQ_WDOG_EN
  input  logic             wdog_kick,
  output logic             wdog_fired,
`endif
  output logic [N_OUT-1:0] rst_out,
  output logic             rst_done,
  output logic             busy
);

  localparam int unsigned IdxW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CNT_W-1:0] StretchCnt = CNT_W'(STRETCH);
  // Reload one short so consecutive releases are exactly STAGGER edges apart.
  localparam logic [CNT_W-1:0] StaggerCnt = CNT_W'(STAGGER - 1);
  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(N_OUT - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [N_OUT-1:0]  rst_out_q, rst_out_d;
  logic              rst_sync;
  logic              wdog_hit;
  logic              restart;

  rst_sequencer_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_sync (rst_sync)
  );

  assign restart = soft_rst_req | wdog_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StAssert;
      cnt_q     <= StretchCnt;
      idx_q     <= '0;
      rst_out_q <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    if (rst_sync || restart) begin
      state_d   = StAssert;
      cnt_d     = StretchCnt;
      idx_d     = '0;
      rst_out_d = '1;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == '0) begin
            rst_out_d[0] = 1'b0;
            if (N_OUT == 1) begin
              state_d = StRun;
            end else begin
              state_d = StRelease;
              cnt_d   = StaggerCnt;
              idx_d   = IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StRelease: begin
          if (cnt_q == '0) begin
            rst_out_d[idx_q] = 1'b0;
            if (idx_q == LastIdx) begin
              state_d = StRun;
            end else begin
              cnt_d = StaggerCnt;
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StRun: ;
        default: begin
          state_d   = StAssert;
          cnt_d     = StretchCnt;
          idx_d     = '0;
          rst_out_d = '1;
        end
      endcase
    end
  end

  always_comb begin
    rst_done = (state_q == StRun);
    busy     = (state_q != StRun);
  end

  assign rst_out = rst_out_q;

`ifdef RST_SEQ_WDOG_EN
  logic [31:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_fired_q;

  // Fires on the edge the counter would reach WDOG_CYCLES-1.
  assign wdog_hit = (state_q == StRun) && !wdog_kick && (wdog_cnt_q == 32'(WDOG_CYCLES - 2));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q + 32'd1;
    if (state_q != StRun || wdog_kick || wdog_hit) begin
      wdog_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q   <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_fired_q <= wdog_fired_q | wdog_hit;
    end
  end

  assign wdog_fired = wdog_fired_q;
`else
  assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomised bench for rst_sequencer; the model tracks the edge at which bit 0 is due to fall.
module tb_rst_sequencer;

  localparam int NOUT    = 3;
  localparam int STRETCH = 8;
  localparam int STAGGER = 4;
  localparam int SYNC    = 2;
  localparam int WDOG    = 16;
  localparam int INF     = 1 << 30;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            soft_rst_req = 1'b0;
  logic            wdog_kick = 1'b0;
  logic [NOUT-1:0] rst_out;
  logic            rst_done;
  logic            busy;
`ifdef RST_SEQ_WDOG_EN
  logic            wdog_fired;
`endif

  int n_chk = 0;
  int n_bad = 0;

  // Model: absolute edge count, edge where bit 0 falls, last in-RUN kick edge.
  int edge_n    = 0;
  int start     = INF;
  int last_kick = -1;
  bit fired_m   = 1'b0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .N_OUT       (NOUT),
    .CNT_W       (16),
    .STRETCH     (STRETCH),
    .STAGGER     (STAGGER),
    .SYNC_STAGES (SYNC)
`ifdef RST_SEQ_WDOG_EN
    ,
    .WDOG_CYCLES (WDOG)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
`ifdef RST_SEQ_WDOG_EN
    .wdog_kick    (wdog_kick),
    .wdog_fired   (wdog_fired),
`endif
    .rst_out      (rst_out),
    .rst_done     (rst_done),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
    end
  endtask

  function automatic int run_edge();
    return start + (NOUT - 1) * STAGGER;
  endfunction

  task automatic model_edge(input bit sreq, input bit kick);
    int  e;
    int  ref_e;
    bit  in_run;
    bit  fire;
    e      = edge_n;
    in_run = (e - 1) >= run_edge();
    ref_e  = (last_kick > run_edge()) ? last_kick : run_edge();
    fire   = 1'b0;
`ifdef RST_SEQ_WDOG_EN
    fire = in_run && !kick && (e == ref_e + WDOG - 1);
`endif
    if (in_run && kick) last_kick = e;
    if ((sreq || fire) && (e + STRETCH + 1 > start)) start = e + STRETCH + 1;
    if (fire) fired_m = 1'b1;
  endtask

  task automatic compare_all();
    logic [NOUT-1:0] exp_out;
    logic            exp_done;
    for (int i = 0; i < NOUT; i++) exp_out[i] = !(edge_n >= start + i * STAGGER);
    exp_done = (edge_n >= run_edge());
    check_eq("rst_out", 32'(rst_out), 32'(exp_out));
    check_eq("rst_done", 32'(rst_done), 32'(exp_done));
    check_eq("busy", 32'(busy), 32'(!exp_done));
`ifdef RST_SEQ_WDOG_EN
    check_eq("wdog_fired", 32'(wdog_fired), 32'(fired_m));
`endif
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic step(input bit sreq, input bit kick);
    soft_rst_req = sreq;
    wdog_kick    = kick;
    @(posedge clk);
    edge_n++;
    if (!rst) model_edge(sreq, kick);
    @(negedge clk);
    compare_all();
  endtask

  // Asserts rst between edges, checks the async effect, holds, then releases at a negedge.
  task automatic do_reset(input int cycles);
    soft_rst_req = 1'b0;
    #2 rst = 1'b1;
    start     = INF;
    last_kick = -1;
    fired_m   = 1'b0;
    #1 compare_all();
    @(negedge clk);
    repeat (cycles) step(1'b0, 1'b0);
    rst   = 1'b0;
    start = edge_n + 1 + SYNC + STRETCH;
  endtask

  initial begin
    int r;
    @(negedge clk);
    // Power-on
    do_reset(5);
    repeat (25) step(1'b0, 1'b1);

    // Soft reset in RUN
    step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);

    // Soft reset in RELEASE, after bit 0 fell
    step(1'b1, 1'b1);
    for (int i = 0; i < 40 && edge_n < start; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_eq("mid_release_bit0", 32'(rst_out[0]), 32'd0);
    step(1'b1, 1'b1);
    check_eq("soft_reassert", 32'(rst_out), 32'h7);
    repeat (22) step(1'b0, 1'b1);

    // Async reset mid-ASSERT and mid-RELEASE
    do_reset(2);
    repeat (6) step(1'b0, 1'b1);
    do_reset(2);
    repeat (12) step(1'b0, 1'b1);
    do_reset(3);
    repeat (25) step(1'b0, 1'b1);

    // Random traffic
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset($urandom_range(1, 4));
      else step(r < 6, $urandom_range(0, 9) == 0);
    end

`ifdef RST_SEQ_WDOG_EN
    do_reset(2);
    repeat (25) step(1'b0, 1'b1);
    repeat (6) begin
      step(1'b0, 1'b1);
      repeat (9) step(1'b0, 1'b0);
    end
    check_eq("wdog_quiet", 32'(wdog_fired), 32'd0);
    repeat (30) step(1'b0, 1'b0);
    check_eq("wdog_fired_set", 32'(wdog_fired), 32'd1);
    repeat (20) step(1'b0, 1'b1);
    check_eq("wdog_fired_sticky", 32'(wdog_fired), 32'd1);
    do_reset(2);
    check_eq("wdog_fired_clr", 32'(wdog_fired), 32'd0);
    repeat (5) step(1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
